// File: rtl/cond_fetch_unit_pkg.sv
// Shared definitions for the conditional fetch unit: ARM condition codes,
// flag bit positions and the word/flag types used across the block.
package cond_fetch_unit_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int WORD_BYTES = 4;

    typedef logic [3:0]  cond_t;
    typedef logic [3:0]  flags_t;
    typedef logic [31:0] word_t;

    // Signed-comparison helper shared by GE/LT/GT/LE: true when N equals V.
    function automatic logic n_eq_v(input flags_t f);
        return f[FLAG_N] == f[FLAG_V];
    endfunction

endpackage

// File: rtl/cond_fetch_unit_cond_eval.sv
// Pure combinational ARM condition-code decoder: maps a 4-bit condition
// field and the {N,Z,C,V} flags to a single "condition holds" bit.
module cond_eval
    import cond_fetch_unit_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       asserted
);

    logic n;
    logic z;
    logic c;
    logic v;
    logic nv_eq;

    assign n     = flags[FLAG_N];
    assign z     = flags[FLAG_Z];
    assign c     = flags[FLAG_C];
    assign v     = flags[FLAG_V];
    assign nv_eq = n_eq_v(flags);

    // NV is reserved and never executes, so it decodes to 0 like the default.
    always_comb begin
        asserted = 1'b0;
        unique case (cond)
            COND_EQ: asserted = z;
            COND_NE: asserted = !z;
            COND_CS: asserted = c;
            COND_CC: asserted = !c;
            COND_MI: asserted = n;
            COND_PL: asserted = !n;
            COND_VS: asserted = v;
            COND_VC: asserted = !v;
            COND_HI: asserted = c && !z;
            COND_LS: asserted = !c || z;
            COND_GE: asserted = nv_eq;
            COND_LT: asserted = !nv_eq;
            COND_GT: asserted = !z && nv_eq;
            COND_LE: asserted = z || !nv_eq;
            COND_AL: asserted = 1'b1;
            COND_NV: asserted = 1'b0;
            default: asserted = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_fetch_unit.sv
// Fetch-stage helper: byte-addressed instruction memory with a big-endian
// word read port, the status flag register and the branch-taken decision.
module cond_fetch_unit
    import cond_fetch_unit_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_en,
    input  logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_dout,
    input  logic              ld_we,
    input  logic [7:0]        ld_addr,
    input  logic [7:0]        ld_data,
    input  logic [3:0]        cc_in,
    input  logic              s,
    output logic [3:0]        cc_out,
    input  logic [3:0]        instr_cond,
    input  logic              b_instr,
    output logic              asserted,
    output logic              choose_ta_r_nop
);

    localparam int AW = $clog2(MEM_DEPTH);

    logic [7:0]    mem [MEM_DEPTH];
    logic [AW-1:0] base_addr;
    word_t         rd_word;
    flags_t        status_q;
    logic          cond_true;
    logic          unused_addr_bits;

    assign base_addr        = mem_addr[AW-1:0];
    assign unused_addr_bits = ^{mem_addr[ADDR_W-1:AW], ld_addr};

    // Preload port; memory is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (ld_we) begin
            mem[ld_addr[AW-1:0]] <= ld_data;
        end
    end

    // Byte offsets are added in AW bits so the word wraps around the array.
    always_comb begin
        rd_word = '0;
        if (mem_en) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                rd_word[31 - 8*i -: 8] = mem[base_addr + AW'(i)];
            end
        end
    end

    assign mem_dout = rd_word;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            status_q <= '0;
        end else if (s) begin
            status_q <= cc_in;
        end
    end

    assign cc_out = status_q;

    // Evaluate on the live ALU flags so a flag-setting op feeds its own branch.
    cond_eval u_cond_eval (
        .cond     (instr_cond),
        .flags    (cc_in),
        .asserted (cond_true)
    );

    assign asserted        = cond_true;
    assign choose_ta_r_nop = cond_true & b_instr;

endmodule

// File: tb/tb_cond_fetch_unit.sv
// Self-checking bench for cond_fetch_unit: directed literal checks plus a
// randomized phase compared every cycle against a behavioural model.
module tb_cond_fetch_unit;

    logic        clk;
    logic        reset;
    logic        mem_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_dout;
    logic        ld_we;
    logic [7:0]  ld_addr;
    logic [7:0]  ld_data;
    logic [3:0]  cc_in;
    logic        s;
    logic [3:0]  cc_out;
    logic [3:0]  instr_cond;
    logic        b_instr;
    logic        asserted;
    logic        choose_ta_r_nop;

    int checks = 0;
    int errors = 0;
    bit check_en = 0;

    byte unsigned ref_mem [256];
    logic [3:0]   ref_cc;

    cond_fetch_unit #(.MEM_DEPTH(256), .ADDR_W(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .mem_en          (mem_en),
        .mem_addr        (mem_addr),
        .mem_dout        (mem_dout),
        .ld_we           (ld_we),
        .ld_addr         (ld_addr),
        .ld_data         (ld_data),
        .cc_in           (cc_in),
        .s               (s),
        .cc_out          (cc_out),
        .instr_cond      (instr_cond),
        .b_instr         (b_instr),
        .asserted        (asserted),
        .choose_ta_r_nop (choose_ta_r_nop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ARM-style decode: bits [3:1] pick a base test, bit 0 inverts it.
    function automatic logic model_cond(input logic [3:0] code, input logic [3:0] f);
        bit n, z, c, v, base;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (code[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return base ^ code[0];
    endfunction

    function automatic logic [31:0] model_word(input logic en, input logic [31:0] addr);
        int a;
        logic [31:0] w;
        if (!en) return 32'h0;
        a = int'(addr % 256);
        w = {ref_mem[a], ref_mem[(a + 1) % 256], ref_mem[(a + 2) % 256], ref_mem[(a + 3) % 256]};
        return w;
    endfunction

    always @(posedge clk) begin
        if (ld_we) ref_mem[ld_addr] <= ld_data;
    end

    always @(posedge clk or posedge reset) begin
        if (reset) ref_cc <= 4'b0000;
        else if (s) ref_cc <= cc_in;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (check_en) begin
            logic exp_a;
            exp_a = model_cond(instr_cond, cc_in);
            checkOutput("model_dout",   mem_dout, model_word(mem_en, mem_addr));
            checkOutput("model_assert", {31'b0, asserted}, {31'b0, exp_a});
            checkOutput("model_choose", {31'b0, choose_ta_r_nop}, {31'b0, exp_a & b_instr});
            checkOutput("model_cc",     {28'b0, cc_out}, {28'b0, ref_cc});
        end
    end

    task automatic applyStimulus(input logic en, input logic [31:0] addr, input logic [3:0] cc,
                                 input logic [3:0] cond, input logic br, input logic set);
        mem_en = en; mem_addr = addr; cc_in = cc; instr_cond = cond; b_instr = br; s = set;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic loadByte(input logic [7:0] a, input logic [7:0] d);
        ld_we = 1'b1; ld_addr = a; ld_data = d;
        nextCycle();
        ld_we = 1'b0;
    endtask

    initial begin
        logic [7:0] pre [8];
        pre = '{8'hE3, 8'hA0, 8'h10, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
        reset = 1'b1;
        ld_we = 1'b0; ld_addr = '0; ld_data = '0;
        applyStimulus(1'b0, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        #2;
        checkOutput("reset_cc", {28'b0, cc_out}, 32'h0);
        nextCycle();
        reset = 1'b0;

        for (int i = 0; i < 256; i++) loadByte(8'(i), 8'($urandom));
        for (int i = 0; i < 8; i++) loadByte(8'(i), pre[i]);
        check_en = 1'b1;

        applyStimulus(1'b1, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        @(negedge clk); checkOutput("read_addr0", mem_dout, 32'hE3A01001);
        nextCycle();
        applyStimulus(1'b1, 32'h4, 4'h0, 4'h0, 1'b0, 1'b0);
        @(negedge clk); checkOutput("read_addr4", mem_dout, 32'h11223344);
        nextCycle();
        applyStimulus(1'b0, 32'h4, 4'h0, 4'h0, 1'b0, 1'b0);
        @(negedge clk); checkOutput("read_disabled", mem_dout, 32'h0);
        nextCycle();

        loadByte(8'd254, 8'hAA);
        loadByte(8'd255, 8'hBB);
        loadByte(8'd0, 8'hCC);
        loadByte(8'd1, 8'hDD);
        applyStimulus(1'b1, 32'd254, 4'h0, 4'h0, 1'b0, 1'b0);
        @(negedge clk); checkOutput("read_wrap", mem_dout, 32'hAABBCCDD);
        nextCycle();
        applyStimulus(1'b1, 32'h0000_0100, 4'h0, 4'h0, 1'b0, 1'b0);
        @(negedge clk); checkOutput("read_alias", mem_dout, {16'hCCDD, 8'h10, 8'h01});
        nextCycle();

        applyStimulus(1'b1, 32'h0, 4'b0011, 4'b1011, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("lt_asserted", {31'b0, asserted}, 32'h1);
        checkOutput("lt_choose",   {31'b0, choose_ta_r_nop}, 32'h1);
        nextCycle();
        b_instr = 1'b0;
        @(negedge clk); checkOutput("lt_no_branch", {31'b0, choose_ta_r_nop}, 32'h0);
        nextCycle();

        applyStimulus(1'b1, 32'h0, 4'b0100, 4'b0000, 1'b1, 1'b0);
        @(negedge clk); checkOutput("z_eq", {31'b0, asserted}, 32'h1);
        instr_cond = 4'b0001; #1 checkOutput("z_ne", {31'b0, asserted}, 32'h0);
        instr_cond = 4'b1101; #1 checkOutput("z_le", {31'b0, asserted}, 32'h1);
        instr_cond = 4'b1100; #1 checkOutput("z_gt", {31'b0, asserted}, 32'h0);
        nextCycle();

        for (int code = 0; code < 16; code++) begin
            for (int f = 0; f < 16; f++) begin
                applyStimulus(1'b1, 32'($urandom), 4'(f), 4'(code), 1'($urandom), 1'b0);
                @(negedge clk);
                if (code == 14) checkOutput("al_always", {31'b0, asserted}, 32'h1);
                if (code == 15) checkOutput("nv_never",  {31'b0, asserted}, 32'h0);
                nextCycle();
            end
        end

        applyStimulus(1'b1, 32'h0, 4'b1010, 4'h0, 1'b0, 1'b1);
        nextCycle();
        checkOutput("cc_load", {28'b0, cc_out}, 32'hA);
        applyStimulus(1'b1, 32'h0, 4'b0101, 4'h0, 1'b0, 1'b0);
        nextCycle();
        checkOutput("cc_hold", {28'b0, cc_out}, 32'hA);
        reset = 1'b1;
        #1 checkOutput("cc_async_reset", {28'b0, cc_out}, 32'h0);
        nextCycle();
        reset = 1'b0;

        applyStimulus(1'b1, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        ld_we = 1'b1; ld_addr = 8'h00; ld_data = 8'h7F;
        @(negedge clk); checkOutput("hazard_before", {24'b0, mem_dout[31:24]}, 32'hCC);
        nextCycle();
        ld_we = 1'b0;
        @(negedge clk); checkOutput("hazard_after", {24'b0, mem_dout[31:24]}, 32'h7F);
        nextCycle();

        for (int i = 0; i < 2000; i++) begin
            applyStimulus(1'($urandom), 32'($urandom), 4'($urandom), 4'($urandom),
                          1'($urandom), 1'($urandom));
            ld_we = ($urandom_range(0, 3) == 0);
            ld_addr = 8'($urandom); ld_data = 8'($urandom);
            reset = ($urandom_range(0, 49) == 0);
            nextCycle();
        end
        reset = 1'b0; ld_we = 1'b0;
        nextCycle();
        check_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/cond_fetch_unit.md
Name: cond_fetch_unit

Overview:
Front-end helper for the pipelined ARM-style control unit. It combines a byte-addressed 256x8 instruction memory with a 32-bit word read port, a 4-bit status (flags) register, an ARM condition-code evaluator and a branch condition handler. The handler tells the fetch stage whether to take the branch target address or continue sequentially.

Parameters:
MEM_DEPTH, 256, number of bytes in instruction memory; address bits used = log2(MEM_DEPTH).
ADDR_W, 32, width of the fetch address port.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high; clears the status register only.
mem_en  in  1  instruction read enable.
mem_addr  in  32  byte address of the instruction word.
mem_dout  out  32  instruction word.
ld_we  in  1  preload write enable, synchronous.
ld_addr  in  8  preload byte address.
ld_data  in  8  preload byte.
cc_in  in  4  ALU flags {N,Z,C,V}: bit3=N, bit2=Z, bit1=C, bit0=V.
s  in  1  set-flags strobe; the register loads cc_in on the clock edge when s=1.
cc_out  out  4  registered flags.
instr_cond  in  4  instruction bits [31:28].
b_instr  in  1  current instruction is a branch.
asserted  out  1  condition true.
choose_ta_r_nop  out  1  1 = take branch target address; 0 = sequential / NOP path.

Behaviour:
- Connection: one clock (clk) and an asynchronous, active-high reset (reset). Reset is fixed by decision.
- Memory read is combinational:
  - When mem_en=1, mem_dout = {M[a], M[a+1], M[a+2], M[a+3]} with a = mem_addr[7:0]. The word is big-endian, so the lowest address is the MSB.
  - The a+1..a+3 addresses wrap modulo 256. Unaligned addresses are legal and read the four consecutive bytes.
  - Upper address bits are ignored.
  - When mem_en=0, mem_dout = 32'h0.
- Memory write: on the rising clk edge with ld_we=1, M[ld_addr] <= ld_data.
  - A simultaneous read of the same byte returns the old value until the edge.
  - Reset does not clear memory; contents are undefined until loaded.
- Status register:
  - Async reset forces cc_out=4'b0000.
  - Otherwise, on the rising clk edge with s=1, cc_out <= cc_in; with s=0 it holds.
- Condition evaluation is combinational on cc_in, not cc_out, so flags from the current ALU op are forwarded. Codes for instr_cond:
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 CS: C
  - 0011 CC: !C
  - 0100 MI: N
  - 0101 PL: !N
  - 0110 VS: V
  - 0111 VC: !V
  - 1000 HI: C & !Z
  - 1001 LS: !C | Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: !Z & (N==V)
  - 1101 LE: Z | (N!=V)
  - 1110 AL: 1
  - 1111 NV (reserved): 0
- choose_ta_r_nop = asserted & b_instr, combinational. It must be 0 whenever b_instr=0, regardless of the condition.
- Latency: all outputs except cc_out have zero cycles of latency; cc_out has one clock edge.
- Reset mid-operation: cc_out clears immediately. Combinational outputs are unaffected by reset.
- No X propagation on outputs once inputs are known.

Decomposition:
- Shared package:
  - condition-code localparams (COND_EQ … COND_NV)
  - flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0)
- Sub-module: cond_eval, a pure combinational 16-way decoder. The memory, status register and handler stay inline in the top level.

Test Plan:
- Preload bytes 0..7 = 8'hE3, 8'hA0, 8'h10, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44; mem_en=1, addr=0 -> mem_dout=32'hE3A01001. Then addr=4 -> 32'h11223344. With mem_en=0 -> 32'h0.
- Wrap: bytes 254,255,0,1 = AA, BB, CC, DD; addr=254 -> 32'hAABBCCDD. Addr 32'h0000_0100 aliases to addr 0.
- cc_in=4'b0011, instr_cond=4'b1011 (LT), b_instr=1 -> asserted=1, choose_ta_r_nop=1. Same inputs with b_instr=0 -> choose_ta_r_nop=0.
- Sweep all 16 codes against all 16 flag combinations and compare with the table above. Spot checks:
  - Z=1 gives EQ=1, NE=0, LE=1, GT=0.
  - Code 1110 always gives 1; code 1111 always gives 0.
- Status register:
  - reset=1 -> cc_out=0 without a clock edge.
  - Release reset; s=1, cc_in=4'b1010, rising edge -> cc_out=4'b1010.
  - s=0, cc_in=4'b0101, edge -> cc_out holds 4'b1010.
  - Assert reset between edges -> cc_out=0 immediately.
- Write/read hazard: ld_we=1 to address 0 with data 8'h7F while reading addr 0 -> old byte before the edge, 8'h7F in MSB after the edge.
